imem_loader: RTL and testbench

- Write-side counterpart of the byte-addressed, big-endian instruction memory.
- Receives a framed byte stream over a valid/ready handshake and writes each byte into the instruction-memory byte array at consecutive addresses.
- MSB byte of each instruction word lands at the lowest address.
- Holds the CPU while loading; reports completion or a checksum/length error.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_loader_csum.sv | 17 +
 rtl/imem_loader.sv | 123 ++++++++++++
 tb/tb_imem_loader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: loader FSM encoding and instruction-memory geometry shared with the memory.
package imem_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_ERR
  } state_t;
  localparam int IMEM_BYTES = 256;
  localparam int IMEM_MAX_WORDS = IMEM_BYTES / 4;
  localparam int FRAME_OVH = 3;
  function automatic logic [15:0] last_idx(input logic [15:0] n);
    return {n[13:0], 2'b00} - 16'd1;
  endfunction
endpackage

// File: rtl/imem_loader_csum.sv
// imem_loader_csum: XOR accumulator over the data bytes of one frame.
module imem_loader_csum (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_data,
  output logic [7:0] o_csum
);
  logic [7:0] r_csum;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_csum <= '0;
    else if (i_clr) r_csum <= '0;
    else if (i_en) r_csum <= r_csum ^ i_data;
  end
  assign o_csum = r_csum;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream to big-endian instruction memory, holding the CPU while loading.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MEM_BYTES = IMEM_BYTES,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [15:0]       o_words_loaded
);
  localparam int MAX_WORDS = MEM_BYTES / 4;
  state_t            r_state;
  logic [15:0]       r_n;
  logic [15:0]       r_idx;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_cpu_hold;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [15:0]       r_words;
  logic              w_acc;
  logic              w_clr;
  logic              w_en;
  logic [7:0]        w_csum;
  logic [15:0]       w_n;
  assign o_in_ready = r_state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
  assign w_acc      = i_in_valid && o_in_ready;
  assign w_clr      = (r_state == S_IDLE) && i_start;
  assign w_en       = w_acc && (r_state == S_DATA);
  assign w_n        = {r_n[15:8], i_in_data};
  imem_loader_csum u_csum (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_data (i_in_data),
    .o_csum (w_csum)
  );
  // Every output is registered; hold/busy drop on the same edge that re-enters IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_idx       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_words     <= '0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state    <= S_LEN_HI;
          r_error    <= 1'b0;
          r_idx      <= '0;
          r_cpu_hold <= 1'b1;
          r_busy     <= 1'b1;
        end
        S_LEN_HI: if (w_acc) begin
          r_n[15:8] <= i_in_data;
          r_state   <= S_LEN_LO;
        end
        S_LEN_LO: if (w_acc) begin
          r_n     <= w_n;
          r_words <= w_n;
          r_state <= (w_n > 16'(MAX_WORDS)) ? S_ERR : (w_n == 16'd0) ? S_CSUM : S_DATA;
        end
        S_DATA: if (w_acc) begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= ADDR_W'(BASE_ADDR) + r_idx[ADDR_W-1:0];
          r_mem_wdata <= i_in_data;
          r_idx       <= r_idx + 16'd1;
          if (r_idx == last_idx(r_n)) r_state <= S_CSUM;
        end
        S_CSUM: if (w_acc) begin
          if (i_in_data == w_csum) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
            r_busy     <= 1'b0;
          end else begin
            r_state <= S_ERR;
          end
        end
        S_ERR: begin
          r_error    <= 1'b1;
          r_state    <= S_IDLE;
          r_cpu_hold <= 1'b0;
          r_busy     <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_cpu_hold     = r_cpu_hold;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_words_loaded = r_words;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames against imem_loader with hand-computed expectations.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic        i_in_valid = 1'b0;
  logic [7:0]  i_in_data = 8'h00;
  logic        o_in_ready;
  logic        o_mem_we;
  logic [7:0]  o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic        o_cpu_hold;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [15:0] o_words_loaded;
  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [7:0] dq[$];
  always #5 clk = ~clk;
  imem_loader dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_in_valid     (i_in_valid),
    .i_in_data      (i_in_data),
    .o_in_ready     (o_in_ready),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .o_cpu_hold     (o_cpu_hold),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_words_loaded (o_words_loaded)
  );
  always @(negedge clk) begin
    if (o_mem_we) wr_cnt++;
    if (o_done) done_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] xsum();
    logic [7:0] x = 8'h00;
    foreach (dq[i]) x ^= dq[i];
    return x;
  endfunction
  task automatic all_zero(input string tag);
    chk({tag, "_ready"}, 32'(o_in_ready), 0);
    chk({tag, "_we"}, 32'(o_mem_we), 0);
    chk({tag, "_addr"}, 32'(o_mem_addr), 0);
    chk({tag, "_wdata"}, 32'(o_mem_wdata), 0);
    chk({tag, "_hold"}, 32'(o_cpu_hold), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_error"}, 32'(o_error), 0);
    chk({tag, "_words"}, 32'(o_words_loaded), 0);
  endtask
  task automatic do_start;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    chk("start_busy", 32'(o_busy), 1);
    chk("start_hold", 32'(o_cpu_hold), 1);
    chk("start_error_clr", 32'(o_error), 0);
    chk("start_ready", 32'(o_in_ready), 1);
  endtask
  task automatic send(input logic [7:0] b, input bit dat, input logic [7:0] ea, input bit gap);
    int g = 0;
    i_in_valid = 1'b1;
    i_in_data = b;
    while (!o_in_ready && g < 16) begin
      tick;
      g++;
    end
    chk("in_ready_wait", 32'(o_in_ready), 1);
    tick;
    chk("mem_we_latency", 32'(o_mem_we), 32'(dat));
    if (dat) begin
      chk("mem_addr", 32'(o_mem_addr), 32'(ea));
      chk("mem_wdata", 32'(o_mem_wdata), 32'(b));
    end
    if (gap) begin
      i_in_valid = 1'b0;
      tick;
      chk("mem_we_gap", 32'(o_mem_we), 0);
    end
  endtask
  task automatic frame(input logic [15:0] n, input logic [7:0] cs, input bit gap, input bit poke,
                       input bit end_start);
    int w0;
    int d0;
    bit good;
    good = (cs == xsum());
    do_start;
    w0 = wr_cnt;
    d0 = done_cnt;
    i_start = poke;
    send(n[15:8], 1'b0, 8'h00, gap);
    send(n[7:0], 1'b0, 8'h00, gap);
    i_start = 1'b0;
    chk("words_loaded", 32'(o_words_loaded), 32'(n));
    for (int i = 0; i < dq.size(); i++) send(dq[i], 1'b1, 8'(i), gap);
    i_start = end_start;
    send(cs, 1'b0, 8'h00, 1'b0);
    i_start = 1'b0;
    i_in_valid = 1'b0;
    if (good) begin
      chk("done_pulse", 32'(o_done), 1);
      chk("done_hold_fall", 32'(o_cpu_hold), 0);
      chk("done_busy_fall", 32'(o_busy), 0);
      chk("done_error", 32'(o_error), 0);
    end else begin
      chk("err_still_busy", 32'(o_busy), 1);
      chk("err_no_done", 32'(o_done), 0);
      tick;
      chk("err_sticky", 32'(o_error), 1);
      chk("err_busy_fall", 32'(o_busy), 0);
      chk("err_hold_fall", 32'(o_cpu_hold), 0);
    end
    tick;
    chk("done_one_cycle", 32'(o_done), 0);
    chk("idle_after", 32'(o_busy), 0);
    chk("idle_ready", 32'(o_in_ready), 0);
    chk("write_count", 32'(wr_cnt - w0), 32'(dq.size()));
    chk("done_count", 32'(done_cnt - d0), good ? 32'd1 : 32'd0);
  endtask
  initial begin
    int w0;
    #1 rst = 1'b1;
    tick;
    tick;
    all_zero("reset");
    rst = 1'b0;
    tick;
    all_zero("post_reset");
    // nominal: XOR of 24 01 00 08 34 02 00 02 is 0x19
    dq = '{8'h24, 8'h01, 8'h00, 8'h08, 8'h34, 8'h02, 8'h00, 8'h02};
    frame(16'd2, 8'h19, 1'b0, 1'b0, 1'b0);
    frame(16'd2, 8'h19, 1'b1, 1'b0, 1'b0);
    frame(16'd2, 8'h13, 1'b0, 1'b0, 1'b0);
    chk("error_sticky_idle", 32'(o_error), 1);
    // over-length frame, also checks that start clears the old error
    do_start;
    w0 = wr_cnt;
    send(8'h00, 1'b0, 8'h00, 1'b0);
    send(8'h41, 1'b0, 8'h00, 1'b0);
    i_in_valid = 1'b0;
    chk("len_words", 32'(o_words_loaded), 32'h41);
    chk("len_ready_err", 32'(o_in_ready), 0);
    chk("len_busy_err", 32'(o_busy), 1);
    tick;
    chk("len_error", 32'(o_error), 1);
    chk("len_busy", 32'(o_busy), 0);
    chk("len_hold", 32'(o_cpu_hold), 0);
    chk("len_no_writes", 32'(wr_cnt - w0), 0);
    dq.delete();
    frame(16'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) dq.push_back(8'(i * 37 + 5));
    frame(16'd64, xsum(), 1'b0, 1'b0, 1'b0);
    chk("max_last_addr", 32'(o_mem_addr), 32'hff);
    // reset in the middle of the data phase
    dq = '{8'h24, 8'h01, 8'h00, 8'h08, 8'h34, 8'h02, 8'h00, 8'h02};
    do_start;
    send(8'h00, 1'b0, 8'h00, 1'b0);
    send(8'h02, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) send(dq[i], 1'b1, 8'(i), 1'b0);
    i_in_data = dq[3];
    #2 rst = 1'b1;
    #1;
    all_zero("async_reset");
    w0 = wr_cnt;
    tick;
    chk("reset_no_write", 32'(wr_cnt - w0), 0);
    rst = 1'b0;
    i_in_valid = 1'b0;
    tick;
    frame(16'd2, 8'h19, 1'b0, 1'b0, 1'b0);
    frame(16'd2, 8'h19, 1'b0, 1'b1, 1'b1);
    tick;
    tick;
    chk("final_idle", 32'(o_busy), 0);
    chk("final_hold", 32'(o_cpu_hold), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
